// File: rtl/conway_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conway_pkg
//  Description : Shared constants and types for the Conway frame loader:
//                board size defaults, ANSI byte codes, loader state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package conway_pkg;

    // Default board geometry (log2 of width / height)
    localparam int c_log_width_default  = 4;
    localparam int c_log_height_default = 3;

    // Byte codes of the ANSI frame format
    localparam logic [7:0] c_byte_esc   = 8'h1B;
    localparam logic [7:0] c_byte_lbr   = 8'h5B;  // '['
    localparam logic [7:0] c_byte_semi  = 8'h3B;  // ';'
    localparam logic [7:0] c_byte_home  = 8'h48;  // 'H'
    localparam logic [7:0] c_byte_live  = 8'h4F;  // 'O'
    localparam logic [7:0] c_byte_space = 8'h20;  // ' '
    localparam logic [7:0] c_byte_cr    = 8'h0D;
    localparam logic [7:0] c_byte_lf    = 8'h0A;

    // Alternate glyphs, only honoured when the alternate glyph set is built in
    localparam logic [7:0] c_byte_hash  = 8'h23;  // '#' live
    localparam logic [7:0] c_byte_star  = 8'h2A;  // '*' live
    localparam logic [7:0] c_byte_dot   = 8'h2E;  // '.' dead

    // Loader parser states
    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_CSI  = 3'd1,
        ST_SEMI = 3'd2,
        ST_HOME = 3'd3,
        ST_ROW  = 3'd4,
        ST_LF   = 3'd5,
        ST_PAD  = 3'd6
    } loader_state_t;

endpackage : conway_pkg
`default_nettype wire

// File: rtl/conway_glyph_decode.sv
`default_nettype none
// ============================================================================
//  Module      : conway_glyph_decode
//  Description : Combinational classifier for one received byte. Flags live
//                and dead cell glyphs, CR, LF and ESC.
//                Build option: CONWAY_LOADER_ALT_GLYPH_EN adds '#','*' (live)
//                and '.' (dead) to the cell glyph set.
//  Revision    : 1.0  initial release
// ============================================================================
module conway_glyph_decode
    import conway_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_is_live,
    output logic       o_is_dead,
    output logic       o_is_cr,
    output logic       o_is_lf,
    output logic       o_is_esc
);

    // Classify the byte; cell glyph set widens when the alternate set is built in
    always_comb begin
        o_is_live = (i_byte == c_byte_live);
        o_is_dead = (i_byte == c_byte_space);
        o_is_cr   = (i_byte == c_byte_cr);
        o_is_lf   = (i_byte == c_byte_lf);
        o_is_esc  = (i_byte == c_byte_esc);
`ifdef CONWAY_LOADER_ALT_GLYPH_EN
        if ((i_byte == c_byte_hash) || (i_byte == c_byte_star)) begin
            o_is_live = 1'b1;
        end
        if (i_byte == c_byte_dot) begin
            o_is_dead = 1'b1;
        end
`endif
    end

endmodule : conway_glyph_decode
`default_nettype wire

// File: rtl/conway_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : conway_frame_loader
//  Description : Parses an ANSI text frame (ESC [ ; H, then rows of 'O'/space
//                glyphs with optional CR LF row breaks) from the UART byte
//                stream and writes each cell into the board memory.
//                Build option: CONWAY_LOADER_ALT_GLYPH_EN (alternate glyphs,
//                handled inside conway_glyph_decode).
//  Revision    : 1.0  initial release
// ============================================================================
module conway_frame_loader
    import conway_pkg::*;
#(
    parameter int LOG_WIDTH  = c_log_width_default,
    parameter int LOG_HEIGHT = c_log_height_default
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    output logic                            rx_ready,
    output logic                            wr_en,
    output logic [LOG_WIDTH+LOG_HEIGHT-1:0] wr_addr,
    output logic                            wr_data,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            frame_error
);

    localparam int C_AW = LOG_WIDTH + LOG_HEIGHT;

    // Column counter has one extra bit so "row full" (col == WIDTH) is representable
    localparam logic [LOG_WIDTH:0]    c_col_full = {1'b1, {LOG_WIDTH{1'b0}}};
    localparam logic [LOG_WIDTH:0]    c_col_last = {1'b0, {LOG_WIDTH{1'b1}}};
    localparam logic [LOG_HEIGHT-1:0] c_row_last = {LOG_HEIGHT{1'b1}};

    loader_state_t         state_q, state_d;
    logic [LOG_HEIGHT-1:0] row_q, row_d;
    logic [LOG_WIDTH:0]    col_q, col_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  wr_en_q, wr_en_d;
    logic [C_AW-1:0]       wr_addr_q, wr_addr_d;
    logic                  wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  frame_error_q, frame_error_d;

    logic                  w_accept;
    logic                  w_is_live;
    logic                  w_is_dead;
    logic                  w_is_cr;
    logic                  w_is_lf;
    logic                  w_is_esc;

    // Cell write request built by the state logic, applied in one place
    logic                  w_cell_write;
    logic                  w_cell_val;
    logic [LOG_HEIGHT-1:0] w_cell_row;
    logic [LOG_WIDTH:0]    w_cell_col;

    conway_glyph_decode u_glyph_decode (
        .i_byte    (rx_data),
        .o_is_live (w_is_live),
        .o_is_dead (w_is_dead),
        .o_is_cr   (w_is_cr),
        .o_is_lf   (w_is_lf),
        .o_is_esc  (w_is_esc)
    );

    assign w_accept = rx_valid & rx_ready_q;

    // Next-state, counter and output logic of the frame parser
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;
        w_cell_write  = 1'b0;
        w_cell_val    = 1'b0;
        w_cell_row    = row_q;
        w_cell_col    = col_q;

        unique case (state_q)
            ST_HUNT: begin
                if (w_accept && w_is_esc) begin
                    state_d = ST_CSI;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_CSI: begin
                if (w_accept) begin
                    if (rx_data == c_byte_lbr) begin
                        state_d = ST_SEMI;
                    end else begin
                        state_d       = ST_HUNT;
                        frame_error_d = 1'b1;
                    end
                end
            end
            ST_SEMI: begin
                if (w_accept) begin
                    if (rx_data == c_byte_semi) begin
                        state_d = ST_HOME;
                    end else begin
                        state_d       = ST_HUNT;
                        frame_error_d = 1'b1;
                    end
                end
            end
            ST_HOME: begin
                if (w_accept) begin
                    if (rx_data == c_byte_home) begin
                        state_d = ST_ROW;
                    end else begin
                        state_d       = ST_HUNT;
                        frame_error_d = 1'b1;
                    end
                end
            end
            ST_ROW: begin
                if (w_accept) begin
                    if (w_is_live || w_is_dead) begin
                        w_cell_write = 1'b1;
                        w_cell_val   = w_is_live;
                        // A glyph past the end of a row wraps onto the next row
                        if (col_q == c_col_full) begin
                            w_cell_row = row_q + 1'b1;
                            w_cell_col = '0;
                        end
                    end else if (w_is_cr) begin
                        if (col_q == c_col_full) begin
                            state_d = ST_LF;
                        end else begin
                            // First pad cell is issued together with the CR
                            state_d      = ST_PAD;
                            w_cell_write = 1'b1;
                            w_cell_val   = 1'b0;
                        end
                    end else if (w_is_esc) begin
                        state_d       = ST_CSI;
                        row_d         = '0;
                        col_d         = '0;
                        frame_error_d = 1'b1;
                    end else begin
                        state_d       = ST_HUNT;
                        frame_error_d = 1'b1;
                    end
                end
            end
            ST_PAD: begin
                w_cell_write = 1'b1;
                w_cell_val   = 1'b0;
            end
            ST_LF: begin
                if (w_accept) begin
                    if (w_is_lf) begin
                        state_d = ST_ROW;
                        row_d   = row_q + 1'b1;
                        col_d   = '0;
                    end else begin
                        state_d       = ST_HUNT;
                        frame_error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        if (w_cell_write) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {w_cell_row, w_cell_col[LOG_WIDTH-1:0]};
            wr_data_d = w_cell_val;
            row_d     = w_cell_row;
            col_d     = w_cell_col + 1'b1;
            if ((w_cell_row == c_row_last) && (w_cell_col == c_col_last)) begin
                // Last cell of the board closes the frame
                frame_done_d = 1'b1;
                state_d      = ST_HUNT;
            end else if ((state_d == ST_PAD) && (col_d == c_col_full)) begin
                state_d = ST_LF;
            end
        end

        // Handshake drops for one cycle after each byte and stays down while padding
        rx_ready_d = !w_accept && (state_q != ST_PAD);
        busy_d     = (state_d != ST_HUNT);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_HUNT;
            row_q         <= '0;
            col_q         <= '0;
            rx_ready_q    <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            rx_ready_q    <= rx_ready_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign rx_ready    = rx_ready_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;

endmodule : conway_frame_loader
`default_nettype wire

// File: tb/tb_conway_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conway_frame_loader
//  Description : Directed self-checking bench for conway_frame_loader
//                (16x8 board). Honours CONWAY_LOADER_ALT_GLYPH_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conway_frame_loader;

    localparam logic [7:0] B_ESC = 8'h1B;
    localparam logic [7:0] B_LBR = 8'h5B;
    localparam logic [7:0] B_SEM = 8'h3B;
    localparam logic [7:0] B_H   = 8'h48;
    localparam logic [7:0] B_O   = 8'h4F;
    localparam logic [7:0] B_SP  = 8'h20;
    localparam logic [7:0] B_CR  = 8'h0D;
    localparam logic [7:0] B_LF  = 8'h0A;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic       wr_data;
    logic       busy;
    logic       frame_done;
    logic       frame_error;

    conway_frame_loader dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Output monitor, sampled on the falling edge
    int         wr_cnt   = 0;
    int         done_cnt = 0;
    int         err_cnt  = 0;
    logic [6:0] log_addr [1024];
    logic       log_data [1024];
    int         log_cyc  [1024];
    logic       log_rdy  [1024];
    int         done_cyc = 0;
    logic [6:0] done_addr = '0;
    logic       done_with_wr = 1'b0;
    int         err_cyc = 0;
    logic       err_with_wr = 1'b0;

    always @(negedge clk) begin
        if (wr_en) begin
            log_addr[wr_cnt % 1024] = wr_addr;
            log_data[wr_cnt % 1024] = wr_data;
            log_cyc[wr_cnt % 1024]  = cyc;
            log_rdy[wr_cnt % 1024]  = rx_ready;
            wr_cnt = wr_cnt + 1;
        end
        if (frame_done) begin
            done_cnt     = done_cnt + 1;
            done_cyc     = cyc;
            done_addr    = wr_addr;
            done_with_wr = wr_en;
        end
        if (frame_error) begin
            err_cnt     = err_cnt + 1;
            err_cyc     = cyc;
            err_with_wr = wr_en;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present one byte and hold it until the handshake; hs = cycle of the handshake
    task automatic send(input logic [7:0] b, output int hs);
        int waited;
        waited   = 0;
        hs       = -1;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: byte %h rx_ready=0, required 1 within 200 cycles", b);
            rx_valid = 1'b0;
        end else begin
            hs = cyc;
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_n(input logic [7:0] b, input int n);
        int hs;
        for (int i = 0; i < n; i++) send(b, hs);
    endtask

    task automatic send_hdr();
        int hs;
        send(B_ESC, hs);
        send(B_LBR, hs);
        send(B_SEM, hs);
        send(B_H, hs);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset    = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        idle(3);
        n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready: got %b required 0", rx_ready); end
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b required 0", wr_en); end
        n_tests++; if (wr_addr !== 7'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d required 0", wr_addr); end
        n_tests++; if (wr_data !== 1'b0) begin n_fail++; $display("FAIL reset_wr_data: got %b required 0", wr_data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
        n_tests++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_frame_error: got %b required 0", frame_error); end
        reset = 1'b0;
        idle(1);
        n_tests++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_rise: got %b required 1", rx_ready); end
    endtask

    task automatic test_full_frame();
        int base, bd, be, hs, first_hs;
        do_reset();
        base = wr_cnt; bd = done_cnt; be = err_cnt; first_hs = 0;
        send(B_ESC, hs);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_after_esc: got %b required 1", busy); end
        send(B_LBR, hs); send(B_SEM, hs); send(B_H, hs);
        for (int i = 0; i < 128; i++) begin
            send(B_O, hs);
            if (i == 0) first_hs = hs;
        end
        idle(3);
        n_tests++; if (wr_cnt - base !== 128) begin n_fail++; $display("FAIL full_write_count: got %0d required 128", wr_cnt - base); end
        for (int i = 0; i < 128; i++) begin
            n_tests++;
            if (log_addr[base + i] !== 7'(i) || log_data[base + i] !== 1'b1) begin
                n_fail++;
                $display("FAIL full_cell[%0d]: got addr %0d data %b required addr %0d data 1", i, log_addr[base + i], log_data[base + i], i);
            end
        end
        n_tests++; if (log_cyc[base] !== first_hs + 1) begin n_fail++; $display("FAIL full_glyph_latency: got cycle %0d required %0d", log_cyc[base], first_hs + 1); end
        n_tests++; if (done_cnt - bd !== 1) begin n_fail++; $display("FAIL full_done_count: got %0d required 1", done_cnt - bd); end
        n_tests++; if (done_addr !== 7'd127 || done_with_wr !== 1'b1) begin n_fail++; $display("FAIL full_done_with_last: got addr %0d wr_en %b required 127/1", done_addr, done_with_wr); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %b required 0", busy); end
        n_tests++; if (err_cnt - be !== 0) begin n_fail++; $display("FAIL full_no_error: got %0d required 0", err_cnt - be); end
    endtask

    task automatic test_pad();
        int base, bd, hs, cr_hs, lf_hs;
        do_reset();
        base = wr_cnt; bd = done_cnt;
        send_hdr();
        send(B_O, hs); send(B_SP, hs); send(B_O, hs);
        send(B_CR, cr_hs);
        send(B_LF, lf_hs);
        send_n(B_SP, 112);
        idle(3);
        n_tests++; if (wr_cnt - base !== 128) begin n_fail++; $display("FAIL pad_write_count: got %0d required 128", wr_cnt - base); end
        n_tests++; if (log_data[base] !== 1'b1 || log_data[base + 1] !== 1'b0 || log_data[base + 2] !== 1'b1)
            begin n_fail++; $display("FAIL pad_row0_glyphs: got %b%b%b required 101", log_data[base], log_data[base + 1], log_data[base + 2]); end
        for (int j = 3; j < 16; j++) begin
            n_tests++;
            if (log_addr[base + j] !== 7'(j) || log_data[base + j] !== 1'b0 ||
                log_cyc[base + j] !== cr_hs + 1 + (j - 3) || log_rdy[base + j] !== 1'b0) begin
                n_fail++;
                $display("FAIL pad_cell[%0d]: got addr %0d data %b cyc %0d rdy %b required addr %0d data 0 cyc %0d rdy 0",
                         j, log_addr[base + j], log_data[base + j], log_cyc[base + j], log_rdy[base + j], j, cr_hs + 1 + (j - 3));
            end
        end
        n_tests++; if (lf_hs !== cr_hs + 14) begin n_fail++; $display("FAIL pad_ready_return: got LF handshake %0d required %0d", lf_hs, cr_hs + 14); end
        n_tests++; if (log_addr[base + 16] !== 7'd16) begin n_fail++; $display("FAIL pad_row1_start: got addr %0d required 16", log_addr[base + 16]); end
        n_tests++; if (done_cnt - bd !== 1 || done_addr !== 7'd127) begin n_fail++; $display("FAIL pad_done: got count %0d addr %0d required 1/127", done_cnt - bd, done_addr); end
    endtask

    task automatic test_error_x();
        int base, be, hs, x_hs;
        do_reset();
        base = wr_cnt; be = err_cnt;
        send_hdr();
        send_n(B_O, 20);
        send(8'h58, x_hs);
        idle(2);
        n_tests++; if (wr_cnt - base !== 20) begin n_fail++; $display("FAIL errx_write_count: got %0d required 20", wr_cnt - base); end
        n_tests++; if (err_cnt - be !== 1) begin n_fail++; $display("FAIL errx_error_count: got %0d required 1", err_cnt - be); end
        n_tests++; if (err_cyc !== x_hs + 1 || err_with_wr !== 1'b0) begin n_fail++; $display("FAIL errx_error_timing: got cyc %0d wr %b required cyc %0d wr 0", err_cyc, err_with_wr, x_hs + 1); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL errx_busy: got %b required 0", busy); end
        send(B_O, hs);
        idle(2);
        n_tests++; if (wr_cnt - base !== 20 || busy !== 1'b0) begin n_fail++; $display("FAIL errx_discard: got writes %0d busy %b required 20/0", wr_cnt - base, busy); end
    endtask

    task automatic test_bad_header();
        int base, bd, be, hs;
        do_reset();
        be = err_cnt;
        send(B_ESC, hs); send(B_LBR, hs); send(8'h51, hs);
        idle(2);
        n_tests++; if (err_cnt - be !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL badhdr_error: got errors %0d busy %b required 1/0", err_cnt - be, busy); end
        base = wr_cnt; bd = done_cnt;
        send_hdr();
        send_n(B_O, 128);
        idle(3);
        n_tests++; if (wr_cnt - base !== 128 || done_cnt - bd !== 1) begin n_fail++; $display("FAIL badhdr_recovery: got writes %0d done %0d required 128/1", wr_cnt - base, done_cnt - bd); end
        n_tests++; if (err_cnt - be !== 1) begin n_fail++; $display("FAIL badhdr_no_extra_error: got %0d required 1", err_cnt - be); end
    endtask

    task automatic test_restart();
        int base, be, bd, hs, e_hs;
        do_reset();
        base = wr_cnt; be = err_cnt; bd = done_cnt;
        send_hdr();
        send_n(B_O, 10);
        send(B_ESC, e_hs);
        idle(1);
        n_tests++; if (err_cnt - be !== 1 || err_cyc !== e_hs + 1) begin n_fail++; $display("FAIL restart_error: got count %0d cyc %0d required 1/%0d", err_cnt - be, err_cyc, e_hs + 1); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b required 1", busy); end
        send(B_LBR, hs); send(B_SEM, hs); send(B_H, hs);
        send(B_O, hs); send(B_SP, hs);
        idle(2);
        n_tests++; if (wr_cnt - base !== 12) begin n_fail++; $display("FAIL restart_write_count: got %0d required 12", wr_cnt - base); end
        n_tests++; if (log_addr[base + 10] !== 7'd0 || log_data[base + 10] !== 1'b1) begin n_fail++; $display("FAIL restart_cell0: got addr %0d data %b required 0/1", log_addr[base + 10], log_data[base + 10]); end
        n_tests++; if (log_addr[base + 11] !== 7'd1 || log_data[base + 11] !== 1'b0) begin n_fail++; $display("FAIL restart_cell1: got addr %0d data %b required 1/0", log_addr[base + 11], log_data[base + 11]); end
        n_tests++; if (done_cnt - bd !== 0) begin n_fail++; $display("FAIL restart_no_done: got %0d required 0", done_cnt - bd); end
    endtask

    task automatic test_reset_mid();
        int be;
        do_reset();
        be = err_cnt;
        send_hdr();
        send_n(B_O, 50);
        reset = 1'b1;
        idle(1);
        n_tests++; if ({rx_ready, wr_en, wr_data, busy, frame_done, frame_error} !== 6'b0 || wr_addr !== 7'd0)
            begin n_fail++; $display("FAIL midreset_outputs: got rdy%b wr%b addr%0d d%b busy%b done%b err%b required all 0",
                                     rx_ready, wr_en, wr_addr, wr_data, busy, frame_done, frame_error); end
        reset = 1'b0;
        idle(2);
        n_tests++; if (err_cnt - be !== 0) begin n_fail++; $display("FAIL midreset_no_error: got %0d required 0", err_cnt - be); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b required 0", busy); end
    endtask

    task automatic test_alt_glyph();
        int base, be, hs;
        do_reset();
        base = wr_cnt; be = err_cnt;
        send_hdr();
        send(8'h23, hs);
        idle(2);
`ifdef CONWAY_LOADER_ALT_GLYPH_EN
        n_tests++; if (wr_cnt - base !== 1 || log_data[base] !== 1'b1 || log_addr[base] !== 7'd0)
            begin n_fail++; $display("FAIL alt_hash_live: got writes %0d data %b addr %0d required 1/1/0", wr_cnt - base, log_data[base], log_addr[base]); end
        n_tests++; if (err_cnt - be !== 0) begin n_fail++; $display("FAIL alt_hash_no_error: got %0d required 0", err_cnt - be); end
        send(8'h2E, hs);
        idle(2);
        n_tests++; if (wr_cnt - base !== 2 || log_data[base + 1] !== 1'b0 || log_addr[base + 1] !== 7'd1)
            begin n_fail++; $display("FAIL alt_dot_dead: got writes %0d data %b addr %0d required 2/0/1", wr_cnt - base, log_data[base + 1], log_addr[base + 1]); end
`else
        n_tests++; if (err_cnt - be !== 1) begin n_fail++; $display("FAIL alt_hash_error: got %0d required 1", err_cnt - be); end
        n_tests++; if (wr_cnt - base !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL alt_hash_no_write: got writes %0d busy %b required 0/0", wr_cnt - base, busy); end
`endif
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_pad();
        test_error_x();
        test_bad_header();
        test_restart();
        test_reset_mid();
        test_alt_glyph();
        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_conway_frame_loader
`default_nettype wire

// File: doc/conway_frame_loader.md
# conway_frame_loader

Decodes an ANSI text frame arriving on the UART receive byte stream and writes it cell by cell into the Conway board memory, so a host terminal can upload a pattern instead of relying on the LFSR seed. It parses the same byte format the display path emits: ESC `[` `;` `H` home sequence, then rows of `O`/space glyphs with optional CR LF row breaks. It sits between the UART receiver's valid/ready output and a board write port owned by the board-control FSM.

## Interface
Parameters:
- LOG_WIDTH, 4, log2 of board width (WIDTH = 2**LOG_WIDTH)
- LOG_HEIGHT, 3, log2 of board height (HEIGHT = 2**LOG_HEIGHT)

Ports:
- clk  in  1  single design clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data holds an unconsumed byte
- rx_ready  out  1  registered; a byte is consumed on any cycle with rx_valid & rx_ready
- wr_en  out  1  one-cycle board write strobe
- wr_addr  out  LOG_WIDTH+LOG_HEIGHT  cell index, {row, col} = row<<LOG_WIDTH | col
- wr_data  out  1  1 = live, 0 = dead
- busy  out  1  high from accepted ESC until frame done/abort
- frame_done  out  1  one-cycle pulse, full frame written
- frame_error  out  1  one-cycle pulse, frame aborted

## Operation
- States: HUNT, CSI, SEMI, HOME, ROW, LF, PAD.
- HUNT: discard every byte except ESC (0x1B) -> CSI; busy=1, row=0, col=0.
- CSI expects `[` (0x5B) -> SEMI; SEMI expects `;` (0x3B) -> HOME; HOME expects `H` (0x48) -> ROW. Any other byte: frame_error, -> HUNT.
- ROW: col counter is LOG_WIDTH+1 bits, range 0..WIDTH; WIDTH means row full.
  - `O` (0x4F) -> write 1; space (0x20) -> write 0, at {row,col}; col+1.
  - Cell glyph with col==WIDTH and row<HEIGHT-1: implicit wrap, write at {row+1,0}, row+1, col=1.
  - CR (0x0D): col<WIDTH -> PAD; col==WIDTH -> LF.
  - ESC mid-frame: frame_error, restart at CSI (new header). Any other byte: frame_error, -> HUNT.
- PAD: write 0 at {row,col}, col+1, one cell per cycle until col==WIDTH, then -> LF. rx_ready=0 throughout.
- LF expects LF (0x0A): row+1, col=0, -> ROW. Other byte: frame_error, -> HUNT.
- Completion: the write of cell {HEIGHT-1, WIDTH-1} (glyph or pad) pulses frame_done in the same cycle as its wr_en; busy drops, -> HUNT. A trailing CR LF after the last row is discarded in HUNT.
- Partial frames are not rolled back; cells already written stay written.

## Timing
- Reset values: rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, frame_error=0, state HUNT, row=col=0. rx_ready rises the cycle after reset deasserts.
- rx_ready drops for exactly one cycle after each consumed byte (no back-to-back acceptance), and stays low in PAD.
- Glyph consumed at cycle N -> wr_en/wr_addr/wr_data valid at N+1 for one cycle.
- CR consumed at N with col=c<WIDTH -> pad writes at N+1 .. N+(WIDTH-c); rx_ready returns at N+(WIDTH-c)+1.
- frame_error is asserted at N+1 for the offending byte consumed at N; no write occurs in that cycle.
- reset mid-frame aborts immediately with no frame_error pulse.

## Configuration
- CONWAY_LOADER_ALT_GLYPH_EN defined: additionally `#` (0x23) and `*` (0x2A) decode as live, `.` (0x2E) as dead, in ROW.
- Undefined: only `O` and space are cell glyphs; `#`, `*`, `.` in ROW raise frame_error.

## Structure
- Package conway_pkg: LOG_WIDTH/LOG_HEIGHT defaults, byte constants (ESC, `[`, `;`, `H`, `O`, space, CR, LF, alt glyphs), loader state enum.
- Sub-module conway_glyph_decode: combinational byte classifier -> {is_live, is_dead, is_cr, is_lf, is_esc}. It owns the CONWAY_LOADER_ALT_GLYPH_EN switch.

## Test plan
- Header plus 128 `O` with no CR LF -> 128 writes, addr 0..127, data 1; frame_done with the write to addr 127; busy low after.
- Header, row 0 = "O O" CR LF, then 7 full rows of spaces -> addr 0=1, 1=0, 2=1, addr 3..15 pad 0 on consecutive cycles with rx_ready low; frame_done at addr 127.
- Header, 20 glyphs, byte `X` -> 20 writes, then frame_error pulse, busy=0, no further writes; a subsequent `O` is discarded.
- ESC `[` `Q` -> frame_error, HUNT; a fresh valid frame that follows completes normally.
- Mid-row ESC `[` `;` `H` -> frame_error, then writes restart at addr 0.
- reset asserted after 50 glyphs -> all outputs at reset values next cycle, no frame_error; `#` with the macro undefined -> frame_error, with it defined -> write 1.
